// File: rtl/qar_can_pkg.sv
// Shared definitions for the CAN TX scheduler: register word addresses of the
// CAN register block, scheduler FSM encoding and the mailbox payload struct.
package qar_can_pkg;

  // CAN register block word addresses
  localparam logic [5:0] ADDR_STATUS  = 6'h01;
  localparam logic [5:0] ADDR_IRQ_CLR = 6'h05;
  localparam logic [5:0] ADDR_TX_ID   = 6'h08;
  localparam logic [5:0] ADDR_TX_DLC  = 6'h09;
  localparam logic [5:0] ADDR_TX_D0   = 6'h0A;
  localparam logic [5:0] ADDR_TX_D1   = 6'h0B;
  localparam logic [5:0] ADDR_TX_CMD  = 6'h0C;

  // Status bit signalling TX complete, and the matching irq-clear value
  localparam int unsigned STATUS_TX_DONE_BIT = 1;
  localparam logic [31:0] IRQ_TX_CLR         = 32'h0000_0002;

  // Only the 29-bit extended identifier takes part in priority arbitration
  localparam int unsigned ID_CMP_W = 29;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_ARB    = 4'd1,
    ST_WR_ID  = 4'd2,
    ST_WR_DLC = 4'd3,
    ST_WR_D0  = 4'd4,
    ST_WR_D1  = 4'd5,
    ST_TRIG   = 4'd6,
    ST_POLL   = 4'd7,
    ST_CLR    = 4'd8,
    ST_DONE   = 4'd9
  } state_e;

  typedef struct packed {
    logic [31:0] id;
    logic [3:0]  dlc;
    logic [31:0] data0;
    logic [31:0] data1;
  } mb_t;

endpackage

// File: rtl/qar_can_id_arb.sv
// Combinational lowest-ID selector over NUM_MB mailboxes (binary min-tree).
// Ports: valid_i  - mailbox holds a candidate frame
//        id_i     - per-mailbox 29-bit priority identifier
//        win_idx_c / win_valid_c - winning index and "any candidate" flag
// Ties resolve to the lower index because the left (lower) child is kept
// unless the right one is strictly smaller.
module qar_can_id_arb
  import qar_can_pkg::*;
#(
  parameter int unsigned NUM_MB = 4,
  localparam int unsigned IDX_W = $clog2(NUM_MB),
  localparam int unsigned LVLS  = $clog2(NUM_MB)
) (
  input  logic [NUM_MB-1:0]               valid_i,
  input  logic [NUM_MB-1:0][ID_CMP_W-1:0] id_i,
  output logic [IDX_W-1:0]                win_idx_c,
  output logic                            win_valid_c
);

  // Levels 0..LVLS-1; level 0 are the leaves, the root compare is done below
  for (genvar l = 0; l < LVLS; l++) begin : g_lvl
    localparam int unsigned N = NUM_MB >> l;
    logic [N-1:0]               v;
    logic [N-1:0][ID_CMP_W-1:0] id;
    logic [N-1:0][IDX_W-1:0]    ix;

    if (l == 0) begin : g_leaf
      assign v  = valid_i;
      assign id = id_i;
      for (genvar i = 0; i < N; i++) begin : g_ix
        assign ix[i] = IDX_W'(i);
      end
    end else begin : g_node
      for (genvar i = 0; i < N; i++) begin : g_cmp
        logic take_r;
        assign take_r = g_lvl[l-1].v[2*i+1] &&
                        (!g_lvl[l-1].v[2*i] || (g_lvl[l-1].id[2*i+1] < g_lvl[l-1].id[2*i]));
        assign v[i]  = g_lvl[l-1].v[2*i] | g_lvl[l-1].v[2*i+1];
        assign id[i] = take_r ? g_lvl[l-1].id[2*i+1] : g_lvl[l-1].id[2*i];
        assign ix[i] = take_r ? g_lvl[l-1].ix[2*i+1] : g_lvl[l-1].ix[2*i];
      end
    end
  end

  // Root compare between the two surviving candidates
  logic root_take_r;
  assign root_take_r = g_lvl[LVLS-1].v[1] &&
                       (!g_lvl[LVLS-1].v[0] || (g_lvl[LVLS-1].id[1] < g_lvl[LVLS-1].id[0]));
  assign win_valid_c = |g_lvl[LVLS-1].v;
  assign win_idx_c   = root_take_r ? g_lvl[LVLS-1].ix[1] : g_lvl[LVLS-1].ix[0];

endmodule

// File: rtl/qar_can_tx_sched.sv
// CAN TX mailbox scheduler. Holds NUM_MB mailboxes, picks the pending one with
// the lowest identifier, writes it into the CAN register block, triggers TX,
// polls for completion (bounded by POLL_TIMEOUT), clears the TX irq and
// reports completion or timeout.
// Ports: clk, rst_n (async active-low)
//        mb_wr/mb_sel/mb_id/mb_dlc/mb_data0/mb_data1 - mailbox load
//        mb_abort - per-mailbox cancel; mb_pending - mailbox holds unsent frame
//        m_write/m_read/m_addr_word/m_wdata/m_rdata - register master port
//        tx_done/tx_err/tx_idx - completion / timeout pulse and mailbox index
//        busy - scheduler not idle
// All outputs are registered; bus outputs are decoded from the next state so
// they are valid during the cycle the FSM sits in the corresponding state.
module qar_can_tx_sched
  import qar_can_pkg::*;
#(
  parameter int unsigned NUM_MB       = 4,
  parameter int unsigned POLL_TIMEOUT = 1024,
  localparam int unsigned IDX_W       = $clog2(NUM_MB)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mb_wr,
  input  logic [IDX_W-1:0]  mb_sel,
  input  logic [31:0]       mb_id,
  input  logic [3:0]        mb_dlc,
  input  logic [31:0]       mb_data0,
  input  logic [31:0]       mb_data1,
  input  logic [NUM_MB-1:0] mb_abort,
  output logic [NUM_MB-1:0] mb_pending,
  output logic              m_write,
  output logic              m_read,
  output logic [5:0]        m_addr_word,
  output logic [31:0]       m_wdata,
  input  logic [31:0]       m_rdata,
  output logic              tx_done,
  output logic              tx_err,
  output logic [IDX_W-1:0]  tx_idx,
  output logic              busy
);

  localparam int unsigned POLL_CNT_W = $clog2(POLL_TIMEOUT) + 1;

  state_e                 state_q, state_d;
  logic [NUM_MB-1:0]      pending_q, pending_d;
  mb_t                    mb_q [NUM_MB];
  mb_t                    mb_d [NUM_MB];
  logic [IDX_W-1:0]       svc_idx_q, svc_idx_d;
  mb_t                    svc_q, svc_d;
  logic [POLL_CNT_W-1:0]  poll_cnt_q, poll_cnt_d;
  logic                   m_write_q, m_write_d, m_read_q, m_read_d;
  logic [5:0]             m_addr_q, m_addr_d;
  logic [31:0]            m_wdata_q, m_wdata_d;
  logic                   tx_done_q, tx_done_d, tx_err_q, tx_err_d, busy_q, busy_d;
  logic [IDX_W-1:0]       tx_idx_q, tx_idx_d;

  logic [NUM_MB-1:0][ID_CMP_W-1:0] arb_id_c;
  logic [IDX_W-1:0]       arb_idx_c;
  logic                   arb_valid_c;
  logic                   svc_act_c;
  logic [IDX_W-1:0]       svc_cur_c;
  logic                   clr_pend_c;
  logic                   rdata_unused_c;

  assign rdata_unused_c = ^{m_rdata[31:2], m_rdata[0]};

  // Arbitration key: low 29 bits of each stored identifier
  always_comb begin
    for (int unsigned i = 0; i < NUM_MB; i++) begin
      arb_id_c[i] = mb_q[i].id[ID_CMP_W-1:0];
    end
  end

  qar_can_id_arb #(.NUM_MB(NUM_MB)) u_arb (
    .valid_i     (pending_q),
    .id_i        (arb_id_c),
    .win_idx_c   (arb_idx_c),
    .win_valid_c (arb_valid_c)
  );

  // Mailbox in service: the ARB winner is protected already in the ARB cycle
  assign svc_act_c = (state_q == ST_ARB) ? arb_valid_c : (state_q != ST_IDLE);
  assign svc_cur_c = (state_q == ST_ARB) ? arb_idx_c : svc_idx_q;

  // Mailbox load/abort; a write beats an abort, the serviced mailbox is frozen
  always_comb begin
    mb_d      = mb_q;
    pending_d = pending_q;
    for (int unsigned i = 0; i < NUM_MB; i++) begin
      if (!(svc_act_c && (svc_cur_c == IDX_W'(i)))) begin
        if (mb_wr && (mb_sel == IDX_W'(i))) begin
          pending_d[i] = 1'b1;
          mb_d[i]      = '{id: mb_id, dlc: mb_dlc, data0: mb_data0, data1: mb_data1};
        end else if (mb_abort[i]) begin
          pending_d[i] = 1'b0;
        end
      end
    end
    if (clr_pend_c) begin
      pending_d[svc_idx_q] = 1'b0;
    end
  end

  // Next-state and registered-output decode
  always_comb begin
    state_d    = state_q;
    svc_idx_d  = svc_idx_q;
    svc_d      = svc_q;
    poll_cnt_d = '0;
    clr_pend_c = 1'b0;
    tx_done_d  = 1'b0;
    tx_err_d   = 1'b0;
    tx_idx_d   = tx_idx_q;
    m_write_d  = 1'b0;
    m_read_d   = 1'b0;
    m_addr_d   = '0;
    m_wdata_d  = '0;

    case (state_q)
      ST_IDLE:   if (|pending_q) state_d = ST_ARB;
      ST_ARB: begin
        // Pending set may have been aborted between IDLE and ARB
        if (arb_valid_c) begin
          svc_idx_d = arb_idx_c;
          svc_d     = mb_q[arb_idx_c];
          state_d   = ST_WR_ID;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WR_ID:  state_d = ST_WR_DLC;
      ST_WR_DLC: state_d = ST_WR_D0;
      ST_WR_D0:  state_d = ST_WR_D1;
      ST_WR_D1:  state_d = ST_TRIG;
      ST_TRIG:   state_d = ST_POLL;
      ST_POLL: begin
        if (m_rdata[STATUS_TX_DONE_BIT]) begin
          state_d = ST_CLR;
        end else if (poll_cnt_q == POLL_CNT_W'(POLL_TIMEOUT - 1)) begin
          state_d    = ST_IDLE;
          clr_pend_c = 1'b1;
          tx_err_d   = 1'b1;
          tx_idx_d   = svc_idx_q;
        end else begin
          poll_cnt_d = poll_cnt_q + POLL_CNT_W'(1);
        end
      end
      ST_CLR: begin
        state_d    = ST_DONE;
        clr_pend_c = 1'b1;
        tx_done_d  = 1'b1;
        tx_idx_d   = svc_idx_q;
      end
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    case (state_d)
      ST_WR_ID:  begin m_write_d = 1'b1; m_addr_d = ADDR_TX_ID;   m_wdata_d = svc_d.id; end
      ST_WR_DLC: begin m_write_d = 1'b1; m_addr_d = ADDR_TX_DLC;  m_wdata_d = {28'b0, svc_d.dlc}; end
      ST_WR_D0:  begin m_write_d = 1'b1; m_addr_d = ADDR_TX_D0;   m_wdata_d = svc_d.data0; end
      ST_WR_D1:  begin m_write_d = 1'b1; m_addr_d = ADDR_TX_D1;   m_wdata_d = svc_d.data1; end
      ST_TRIG:   begin m_write_d = 1'b1; m_addr_d = ADDR_TX_CMD;  m_wdata_d = '0; end
      ST_POLL:   begin m_read_d  = 1'b1; m_addr_d = ADDR_STATUS; end
      ST_CLR:    begin m_write_d = 1'b1; m_addr_d = ADDR_IRQ_CLR; m_wdata_d = IRQ_TX_CLR; end
      default:   ;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // Mailbox contents carry no reset value
  always_ff @(posedge clk) begin
    mb_q <= mb_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pending_q  <= '0;
      svc_idx_q  <= '0;
      svc_q      <= '0;
      poll_cnt_q <= '0;
      m_write_q  <= 1'b0;
      m_read_q   <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      tx_done_q  <= 1'b0;
      tx_err_q   <= 1'b0;
      tx_idx_q   <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      svc_idx_q  <= svc_idx_d;
      svc_q      <= svc_d;
      poll_cnt_q <= poll_cnt_d;
      m_write_q  <= m_write_d;
      m_read_q   <= m_read_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      tx_done_q  <= tx_done_d;
      tx_err_q   <= tx_err_d;
      tx_idx_q   <= tx_idx_d;
      busy_q     <= busy_d;
    end
  end

  assign mb_pending  = pending_q;
  assign m_write     = m_write_q;
  assign m_read      = m_read_q;
  assign m_addr_word = m_addr_q;
  assign m_wdata     = m_wdata_q;
  assign tx_done     = tx_done_q;
  assign tx_err      = tx_err_q;
  assign tx_idx      = tx_idx_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_qar_can_tx_sched.sv
// Bench for qar_can_tx_sched: transaction-level model of mailboxes and the
// service sequence, compared against the DUT every cycle, plus directed
// scenarios pinned with hand-computed traces.
module tb_qar_can_tx_sched;
  localparam int unsigned NMB = 4;
  localparam int unsigned TO  = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        mb_wr = 1'b0;
  logic [1:0]  mb_sel = '0;
  logic [31:0] mb_id = '0;
  logic [3:0]  mb_dlc = '0;
  logic [31:0] mb_data0 = '0;
  logic [31:0] mb_data1 = '0;
  logic [3:0]  mb_abort = '0;
  logic [31:0] m_rdata = '0;
  logic [3:0]  mb_pending;
  logic        m_write, m_read, tx_done, tx_err, busy;
  logic [5:0]  m_addr_word;
  logic [31:0] m_wdata;
  logic [1:0]  tx_idx;

  always #5 clk = ~clk;

  qar_can_tx_sched #(.NUM_MB(NMB), .POLL_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .mb_wr(mb_wr), .mb_sel(mb_sel), .mb_id(mb_id), .mb_dlc(mb_dlc),
    .mb_data0(mb_data0), .mb_data1(mb_data1), .mb_abort(mb_abort),
    .mb_pending(mb_pending),
    .m_write(m_write), .m_read(m_read), .m_addr_word(m_addr_word),
    .m_wdata(m_wdata), .m_rdata(m_rdata),
    .tx_done(tx_done), .tx_err(tx_err), .tx_idx(tx_idx), .busy(busy)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Model: mailboxes plus a service "phase" (0 idle, 1 select, 2..6 the five
  // register writes, 7 polling, 8 irq clear, 9 completion)
  bit   [3:0]  pend;
  logic [31:0] mid [4];
  logic [31:0] md0 [4];
  logic [31:0] md1 [4];
  logic [3:0]  mdlc [4];
  int          phase, pcnt, svc;
  logic [31:0] s_id, s_d0, s_d1;
  logic [3:0]  s_dlc;
  bit          errf;

  // Observation logs
  logic [37:0] wr_log [$];
  int          done_idx [$];
  int          err_idx [$];
  int          rd_cnt, seen_cyc, done_cyc, err_cyc;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic int m_winner();
    int w = -1;
    for (int i = 0; i < 4; i++)
      if (pend[i] && (w < 0 || mid[i][28:0] < mid[w][28:0])) w = i;
    return w;
  endfunction

  task automatic model_reset();
    pend = '0; phase = 0; pcnt = 0; svc = 0; errf = 1'b0;
  endtask

  task automatic clear_logs();
    wr_log.delete(); done_idx.delete(); err_idx.delete();
    rd_cnt = 0; seen_cyc = -1; done_cyc = -1; err_cyc = -1;
  endtask

  task automatic compare();
    bit          ew, er;
    logic [5:0]  ea;
    logic [31:0] ed;
    int          w, ins;
    bit   [3:0]  pend_old;
    cyc++;
    if (!rst_n) begin
      model_reset();
      chk("reset_outputs", {mb_pending, busy, m_write, m_read, m_addr_word, m_wdata,
                            tx_done, tx_err, tx_idx}, 64'h0);
      return;
    end
    ew = 0; er = 0; ea = '0; ed = '0;
    case (phase)
      2: begin ew = 1; ea = 6'h08; ed = s_id; end
      3: begin ew = 1; ea = 6'h09; ed = {28'b0, s_dlc}; end
      4: begin ew = 1; ea = 6'h0A; ed = s_d0; end
      5: begin ew = 1; ea = 6'h0B; ed = s_d1; end
      6: begin ew = 1; ea = 6'h0C; ed = 32'h0; end
      7: begin er = 1; ea = 6'h01; end
      8: begin ew = 1; ea = 6'h05; ed = 32'h2; end
      default: ;
    endcase
    chk("cycle_outputs",
        {mb_pending, busy, m_write, m_read, m_addr_word, m_wdata, tx_done, tx_err},
        {pend, phase != 0, ew, er, ea, ed, phase == 9, errf});
    if (phase == 9 || errf) chk("tx_idx", 64'(tx_idx), 64'(svc));

    if (m_write === 1'b1) wr_log.push_back({m_addr_word, m_wdata});
    if (m_read === 1'b1) rd_cnt++;
    if (busy === 1'b0 && mb_pending != 0 && seen_cyc < 0) seen_cyc = cyc;
    if (tx_done === 1'b1) begin done_cyc = cyc; done_idx.push_back(int'(tx_idx)); end
    if (tx_err === 1'b1) begin err_cyc = cyc; err_idx.push_back(int'(tx_idx)); end

    // Advance model by one cycle with the inputs currently applied
    w = m_winner();
    ins = (phase == 1) ? w : ((phase >= 2) ? svc : -1);
    pend_old = pend;
    for (int i = 0; i < 4; i++) begin
      if (i != ins) begin
        if (mb_wr && int'(mb_sel) == i) begin
          pend[i] = 1'b1; mid[i] = mb_id; mdlc[i] = mb_dlc; md0[i] = mb_data0; md1[i] = mb_data1;
        end else if (mb_abort[i]) begin
          pend[i] = 1'b0;
        end
      end
    end
    errf = 1'b0;
    case (phase)
      0: if (pend_old != 0) phase = 1;
      1: if (w < 0) phase = 0;
         else begin
           svc = w; s_id = mid[w]; s_dlc = mdlc[w]; s_d0 = md0[w]; s_d1 = md1[w]; phase = 2;
         end
      2, 3, 4, 5: phase++;
      6: begin phase = 7; pcnt = 0; end
      7: if (m_rdata[1]) phase = 8;
         else if (pcnt == TO - 1) begin phase = 0; pend[svc] = 1'b0; errf = 1'b1; end
         else pcnt++;
      8: begin phase = 9; pend[svc] = 1'b0; end
      default: phase = 0;
    endcase
  endtask

  task automatic tick();
    @(negedge clk);
    compare();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [1:0] sel, input logic [31:0] id, input logic [3:0] dlc,
                      input logic [31:0] d0, input logic [31:0] d1);
    mb_wr = 1'b1; mb_sel = sel; mb_id = id; mb_dlc = dlc; mb_data0 = d0; mb_data1 = d1;
    tick();
    mb_wr = 1'b0;
  endtask

  task automatic wait_quiet(input int budget, input string nm);
    int k = 0;
    while (!(busy === 1'b0 && mb_pending === 4'b0) && k < budget) begin tick(); k++; end
    if (k >= budget) begin
      n_checks++; n_errors++;
      $display("FAIL %s: timeout after %0d cycles, busy=%0b pending=%0h", nm, k, busy, mb_pending);
    end
    tick(); tick();
  endtask

  task automatic wait_write(input logic [5:0] a, input int budget, input string nm);
    int k = 0;
    while (!(m_write === 1'b1 && m_addr_word === a) && k < budget) begin tick(); k++; end
    if (k >= budget) begin
      n_checks++; n_errors++;
      $display("FAIL %s: no write to %0h within %0d cycles", nm, a, budget);
    end
  endtask

  function automatic logic [37:0] log_at(input int i);
    return (i < wr_log.size()) ? wr_log[i] : '1;
  endfunction

  logic [37:0] exp_a [6] = '{{6'h08, 32'h123}, {6'h09, 32'h8}, {6'h0A, 32'h11223344},
                             {6'h0B, 32'h55667788}, {6'h0C, 32'h0}, {6'h05, 32'h2}};
  int          exp_b [3] = '{1, 2, 0};

  initial begin
    int n5;
    model_reset();
    clear_logs();
    #1 rst_n = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b1;
    tick();

    // Basic frame with immediate completion
    clear_logs();
    m_rdata = 32'h2;
    load(2'd0, 32'h123, 4'd8, 32'h11223344, 32'h55667788);
    wait_quiet(100, "a_wait");
    chk("a_nwr", 64'(wr_log.size()), 64'd6);
    for (int i = 0; i < 6; i++) chk("a_wr", 64'(log_at(i)), 64'(exp_a[i]));
    chk("a_rd", 64'(rd_cnt), 64'd1);
    chk("a_latency", 64'(done_cyc - seen_cyc), 64'd9);
    chk("a_idx", 64'((done_idx.size() == 1) ? done_idx[0] : 99), 64'd0);

    // Priority order with an id tie
    clear_logs();
    load(2'd1, 32'h100, 4'd1, 32'h1, 32'h1);
    load(2'd2, 32'h100, 4'd2, 32'h2, 32'h2);
    load(2'd0, 32'h200, 4'd3, 32'h3, 32'h3);
    wait_quiet(200, "b_wait");
    chk("b_ndone", 64'(done_idx.size()), 64'd3);
    for (int i = 0; i < 3; i++)
      chk("b_order", 64'((i < done_idx.size()) ? done_idx[i] : 99), 64'(exp_b[i]));

    // Poll timeout
    clear_logs();
    m_rdata = 32'h0;
    load(2'd3, 32'h7, 4'd4, 32'hA, 32'hB);
    wait_quiet(1200, "c_wait");
    n5 = 0;
    foreach (wr_log[i]) if (wr_log[i][37:32] == 6'h05) n5++;
    chk("c_reads", 64'(rd_cnt), 64'd1024);
    chk("c_err_lat", 64'(err_cyc - seen_cyc), 64'd1031);
    chk("c_err_idx", 64'((err_idx.size() == 1) ? err_idx[0] : 99), 64'd3);
    chk("c_no_done", 64'(done_idx.size()), 64'd0);
    chk("c_no_clr", 64'(n5), 64'd0);
    chk("c_nwr", 64'(wr_log.size()), 64'd5);

    // Write/abort to in-service vs. idle pending mailbox
    clear_logs();
    m_rdata = 32'h2;
    load(2'd0, 32'h50, 4'd1, 32'hA0, 32'hB0);
    load(2'd1, 32'h60, 4'd2, 32'hC0, 32'hD0);
    wait_write(6'h0A, 50, "d_wait_d0");
    mb_wr = 1'b1; mb_sel = 2'd0; mb_id = 32'h10; mb_abort = 4'b0001;
    tick();
    mb_wr = 1'b1; mb_sel = 2'd1; mb_id = 32'h61; mb_data0 = 32'hC1; mb_abort = 4'b0010;
    tick();
    mb_wr = 1'b0; mb_abort = 4'b0;
    chk("d_pend", 64'(mb_pending), 64'h3);
    wait_quiet(200, "d_wait");
    chk("d_ndone", 64'(done_idx.size()), 64'd2);
    chk("d_first", 64'((done_idx.size() > 0) ? done_idx[0] : 99), 64'd0);
    chk("d_second", 64'((done_idx.size() > 1) ? done_idx[1] : 99), 64'd1);
    chk("d_id0", 64'(log_at(0)), 64'({6'h08, 32'h50}));
    chk("d_d0", 64'(log_at(2)), 64'({6'h0A, 32'hA0}));
    chk("d_id1", 64'(log_at(6)), 64'({6'h08, 32'h61}));
    chk("d_d1", 64'(log_at(8)), 64'({6'h0A, 32'hC1}));

    // Reset in the middle of a service sequence
    clear_logs();
    load(2'd2, 32'h33, 4'd5, 32'h5, 32'h6);
    wait_write(6'h09, 50, "e_wait_dlc");
    #2 rst_n = 1'b0;
    #1 chk("e_async", {mb_pending, busy, m_write, m_read, m_addr_word, m_wdata,
                       tx_done, tx_err, tx_idx}, 64'h0);
    clear_logs();
    tick(); tick();
    rst_n = 1'b1;
    repeat (20) tick();
    chk("e_nowr", 64'(wr_log.size()), 64'd0);
    chk("e_pend", 64'(mb_pending), 64'h0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      mb_wr    = ($urandom_range(0, 2) == 0);
      mb_sel   = 2'($urandom_range(0, 3));
      mb_id    = ($urandom() & 32'hE000_0000) | 32'($urandom_range(0, 15));
      mb_dlc   = 4'($urandom());
      mb_data0 = $urandom();
      mb_data1 = $urandom();
      mb_abort = 4'($urandom() & $urandom() & $urandom());
      m_rdata  = $urandom();
      m_rdata[1] = ($urandom_range(0, 3) == 0);
      tick();
    end
    mb_wr = 1'b0; mb_abort = 4'b0; m_rdata = 32'h2;
    wait_quiet(2000, "r_wait");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
